reg_scoreboard_ctrl: RTL
========================

// Module: reg_scoreboard_ctrl
// PURPOSE
//  Register-dependence scoreboard and issue controller for the decode stage. Tracks in-flight GPR
//  writes per register, stalls decode on RAW and scoreboard saturation, releases on write-back.
//  Drives decode's ready_go and counts stall cycles. Sits beside the decode stage, fed by its
//  decoded fields and by the write-back port.
// PARAMETERS
//  MAX_INFLIGHT   3   max pending writes tracked per register; CNT_W = clog2(MAX_INFLIGHT+1)
//  STALL_TIMEOUT  64  consecutive stall cycles before timeout is raised
//  PERF_W         32  width of stall_cnt
// PORTS
//  clk          in   1       clock
//  reset        in   1       reset, synchronous, active-high
//  ds_valid     in   1       decode holds a valid instruction
//  ds_rj        in   5       source register 1
//  ds_rj_used   in   1       instruction reads rj
//  ds_rkd       in   5       source register 2 (rk, or rd for stores/branches)
//  ds_rkd_used  in   1       instruction reads rkd
//  ds_dest      in   5       destination register
//  ds_gr_we     in   1       instruction writes a GPR
//  es_allowin   in   1       execute stage accepts this cycle
//  ws_rf_we     in   1       write-back retires a GPR write
//  ws_rf_waddr  in   5       write-back destination
//  flush        in   1       clear all scoreboard state; pipeline is empty behind decode
//  ds_ready_go  out  1       decode may advance
//  ds_issue     out  1       ds_valid & ds_ready_go & es_allowin
//  busy_mask    out  32      bit i = register i has pending write(s); bit 0 always 0
//  stall_cnt    out  PERF_W  total cycles with ds_valid & !ds_ready_go, saturating
//  sb_err       out  1       sticky: retire to a register with zero pending count
//  timeout      out  1       sticky: stall run reached STALL_TIMEOUT
// BEHAVIOUR
//  - Reset: all counters 0, busy_mask 0, stall_cnt 0, sb_err 0, timeout 0. ds_ready_go is
//    combinational: 1 after reset when ds_valid=0.
//  - raw = (ds_rj_used & ds_rj!=0 & cnt[ds_rj]!=0) | (ds_rkd_used & ds_rkd!=0 & cnt[ds_rkd]!=0).
//  - sat = ds_gr_we & ds_dest!=0 & cnt[ds_dest]==MAX_INFLIGHT.
//  - ds_ready_go = !flush & !(ds_valid & (raw | sat)). No same-cycle bypass: a retire in cycle N
//    unblocks the dependent instruction in cycle N+1.
//  - inc = ds_issue & ds_gr_we & ds_dest!=0; dec = ws_rf_we & ws_rf_waddr!=0 & cnt!=0.
//    Same register inc and dec in one cycle: count unchanged. Different registers: both apply.
//  - dec with cnt==0 (waddr!=0): count stays 0, sb_err set (sticky until reset).
//  - Register 0 is never tracked; reads/writes of r0 never stall.
//  - flush (highest priority below reset): next cycle all counters 0, busy_mask 0, stall run
//    counter 0, timeout cleared; ds_ready_go=0 and ds_issue=0 in the flush cycle. Retires
//    in the flush cycle are discarded. stall_cnt and sb_err survive flush.
//  - stall_cnt += 1 each cycle ds_valid & !ds_ready_go & !flush; saturates at 2^PERF_W-1.
//  - Stall run counter: increments on stall cycles, clears on any non-stall cycle; when it
//    reaches STALL_TIMEOUT, timeout is set (sticky until reset or flush).
//  - es_allowin=0 alone is not a scoreboard stall: ds_ready_go stays 1, stall_cnt unchanged.
//  - busy_mask is registered and reflects counters after the current cycle's update.
// TESTING
//  - Issue add r5 (gr_we, dest 5); next instr reads rj=5 -> ds_ready_go=0 until ws_rf_we/waddr=5
//    retires, ds_ready_go=1 the following cycle; stall_cnt equals stall cycles.
//  - Issue 3 writes to r7 back-to-back, 4th write to r7 -> sat stall; one retire of r7 -> 4th
//    issues next cycle, cnt[7] back to 3.
//  - Same cycle: issue write r9 and retire r9 with cnt[9]=1 -> cnt[9] stays 1, busy_mask[9]=1.
//  - Reads/writes of r0 with any history -> never stall, busy_mask[0]=0; retire r12 with
//    cnt[12]=0 -> sb_err=1, counts unchanged.
//  - Hold RAW stall 64 cycles -> timeout=1 at cycle 64; flush -> busy_mask=0, timeout=0,
//    ds_issue=0 that cycle, stall_cnt retained; reset mid-stall -> all outputs to reset values.

Source files
------------

// File: rtl/reg_scoreboard_ctrl.sv
// Register-dependence scoreboard for the decode stage: per-GPR pending-write counters,
// RAW/saturation stall generation, stall statistics and sticky error/timeout flags.
module reg_scoreboard_ctrl #(
  parameter int MAX_INFLIGHT  = 3,
  parameter int STALL_TIMEOUT = 64,
  parameter int PERF_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ds_valid_i,
  input  logic [4:0]        ds_rj_i,
  input  logic              ds_rj_used_i,
  input  logic [4:0]        ds_rkd_i,
  input  logic              ds_rkd_used_i,
  input  logic [4:0]        ds_dest_i,
  input  logic              ds_gr_we_i,
  input  logic              es_allowin_i,
  input  logic              ws_rf_we_i,
  input  logic [4:0]        ws_rf_waddr_i,
  input  logic              flush_i,
  output logic              ds_ready_go_o,
  output logic              ds_issue_o,
  output logic [31:0]       busy_mask_o,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic              sb_err_o,
  output logic              timeout_o
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int RUN_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_TIMEOUT);

  logic [CNT_W-1:0]  cnt_q [32];
  logic [CNT_W-1:0]  cnt_d [32];
  logic [31:0]       busy_q, busy_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              sb_err_q, sb_err_d;
  logic              timeout_q, timeout_d;

  logic raw, sat, stall, inc, incHit, decHit;

  // Hazards are judged against registered counts only, so a retire never bypasses into this cycle.
  always_comb begin
    raw = (ds_rj_used_i  && ds_rj_i  != 5'd0 && cnt_q[ds_rj_i]  != '0) ||
          (ds_rkd_used_i && ds_rkd_i != 5'd0 && cnt_q[ds_rkd_i] != '0);
    sat = ds_gr_we_i && ds_dest_i != 5'd0 && cnt_q[ds_dest_i] == CNT_MAX;
    ds_ready_go_o = !flush_i && !(ds_valid_i && (raw || sat));
    ds_issue_o    = ds_valid_i && ds_ready_go_o && es_allowin_i;
    inc   = ds_issue_o && ds_gr_we_i && ds_dest_i != 5'd0;
    stall = ds_valid_i && !ds_ready_go_o && !flush_i;
  end

  always_comb begin
    incHit = 1'b0;
    decHit = 1'b0;
    for (int i = 0; i < 32; i++) begin
      incHit   = inc && ds_dest_i == 5'(i);
      decHit   = ws_rf_we_i && ws_rf_waddr_i == 5'(i) && cnt_q[i] != '0;
      cnt_d[i] = cnt_q[i];
      if (flush_i || i == 0) begin
        cnt_d[i] = '0;
      end else if (incHit && !decHit) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (decHit && !incHit) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
      busy_d[i] = cnt_d[i] != '0;
    end
  end

  // Retires during a flush are discarded, so they cannot raise sb_err either.
  always_comb begin
    sb_err_d = sb_err_q ||
               (!flush_i && ws_rf_we_i && ws_rf_waddr_i != 5'd0 && cnt_q[ws_rf_waddr_i] == '0);
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    run_d = '0;
    if (stall) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    end
    timeout_d = flush_i ? 1'b0 : (timeout_q || run_d == RUN_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= '0;
      end
      busy_q      <= '0;
      stall_cnt_q <= '0;
      run_q       <= '0;
      sb_err_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
      run_q       <= run_d;
      sb_err_q    <= sb_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy_mask_o = busy_q;
  assign stall_cnt_o = stall_cnt_q;
  assign sb_err_o    = sb_err_q;
  assign timeout_o   = timeout_q;

endmodule
